// File: rtl/ram_async_pkg.sv
// Shared definitions for the asynchronous PSRAM/SRAM controller.
// Holds the controller state enumeration, default timing constants and
// a helper that sizes the timing down-counter.
package ram_async_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_REC  = 3'd4
  } state_e;

  localparam int T_PWRUP_DEF = 15000;
  localparam int T_RD_DEF    = 7;
  localparam int T_WR_DEF    = 7;
  localparam int T_REC_DEF   = 1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Counter holds values 0 .. maxv-1.
  function automatic int cnt_width(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv);
  endfunction

endpackage

// File: rtl/ram_async_ctrl_if.sv
// Request/response bus between a client and ram_async_ctrl.
// master: client side (drives request fields, sees ready/response).
// slave : controller side.
interface ram_async_ctrl_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_rnw_i;
  logic                  req_cre_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic [DATA_W/8-1:0]   req_be_i;
  logic                  rsp_valid_o;
  logic [DATA_W-1:0]     rsp_rdata_o;
  logic                  init_done_o;

  modport master (
    output req_valid_i, req_rnw_i, req_cre_i, req_addr_i, req_wdata_i, req_be_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, init_done_o
  );

  modport slave (
    input  req_valid_i, req_rnw_i, req_cre_i, req_addr_i, req_wdata_i, req_be_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, init_done_o
  );
endinterface

// File: rtl/ram_async_timer.sv
// Loadable down-counter with zero flag. Saturates at zero (never wraps).
// Ports: clk_i clock, load_i load strobe, load_val_i value to load,
//        zero_o high while the count is zero.
module ram_async_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt;

  // Reset is expressed by the owner as a load of the power-up value.
  always_ff @(posedge clk_i) begin
    if (load_i)            cnt <= load_val_i;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero_o = (cnt == '0);
endmodule

// File: rtl/ram_async_ctrl.sv
// Asynchronous-mode PSRAM/SRAM controller.
// Accepts one request at a time on bus (valid/ready), runs a fixed-length
// read or write strobe on the memory pins, pulses rsp_valid_o at the end
// and enforces a chip-select recovery gap. A power-up wait precedes the
// first access (init_done_o).
// Ports: clk_i, reset_i (sync, active high); bus (slave modport);
//        mem_* pins to the memory device, mem_dq_io bidirectional.
module ram_async_ctrl
  import ram_async_pkg::*;
#(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 16,
  parameter int T_PWRUP = T_PWRUP_DEF,
  parameter int T_RD    = T_RD_DEF,
  parameter int T_WR    = T_WR_DEF,
  parameter int T_REC   = T_REC_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  ram_async_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] mem_addr_o,
  inout  wire  [DATA_W-1:0] mem_dq_io,
  output logic              mem_ncs_o,
  output logic              mem_noe_o,
  output logic              mem_nwe_o,
  output logic              mem_nadv_o,
  output logic              mem_clk_o,
  output logic              mem_cre_o,
  output logic              mem_nub_o,
  output logic              mem_nlb_o
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = cnt_width(max4(T_PWRUP, T_RD, T_WR, T_REC));

  typedef struct packed {
    logic              rnw;
    logic              cre;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  state_e            state, nxt;
  req_t              req_q, req_d;
  logic              accept;
  logic              t_zero, t_load;
  logic [CW-1:0]     t_val;
  logic [1:0]        be2;
  logic              dq_oe;
  logic [DATA_W-1:0] dq_out;
  logic              rsp_valid_q, init_done_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign accept = (state == ST_IDLE) && bus.req_valid_i;

  // next-state
  always_comb begin
    nxt = state;
    unique case (state)
      ST_INIT: if (t_zero) nxt = ST_IDLE;
      ST_IDLE: if (bus.req_valid_i) nxt = bus.req_rnw_i ? ST_RD : ST_WR;
      ST_RD,
      ST_WR:   if (t_zero) nxt = ST_REC;
      ST_REC:  if (t_zero) nxt = ST_IDLE;
      default: nxt = ST_INIT;
    endcase
  end

  // Request fields as they will be after this edge; lets the pins be
  // registered straight from the accepting edge.
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.rnw   = bus.req_rnw_i;
      req_d.cre   = bus.req_cre_i;
      req_d.addr  = bus.req_addr_i;
      req_d.wdata = bus.req_wdata_i;
      req_d.be    = bus.req_be_i;
    end
  end

  // Byte enables widened to two lanes; upper lane is 0 for 8-bit parts.
  always_comb begin
    be2           = '0;
    be2[BE_W-1:0] = req_d.be;
  end

  // One timer, reloaded on every state entry with (duration - 1).
  assign t_load = reset_i || (nxt != state);

  always_comb begin
    t_val = '0;
    if (reset_i) t_val = CW'(T_PWRUP - 1);
    else begin
      unique case (nxt)
        ST_INIT: t_val = CW'(T_PWRUP - 1);
        ST_RD:   t_val = CW'(T_RD - 1);
        ST_WR:   t_val = CW'(T_WR - 1);
        ST_REC:  t_val = CW'(T_REC - 1);
        default: t_val = '0;
      endcase
    end
  end

  ram_async_timer #(.W(CW)) u_timer (
    .clk_i      (clk_i),
    .load_i     (t_load),
    .load_val_i (t_val),
    .zero_o     (t_zero)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_INIT;
      req_q       <= '0;
      mem_addr_o  <= '0;
      mem_ncs_o   <= 1'b1;
      mem_noe_o   <= 1'b1;
      mem_nwe_o   <= 1'b1;
      mem_nub_o   <= 1'b1;
      mem_nlb_o   <= 1'b1;
      mem_cre_o   <= 1'b0;
      mem_clk_o   <= 1'b0;
      mem_nadv_o  <= 1'b0;
      dq_oe       <= 1'b0;
      dq_out      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state      <= nxt;
      req_q      <= req_d;
      mem_addr_o <= req_d.addr;
      dq_out     <= req_d.wdata;
      mem_clk_o  <= 1'b0;
      mem_nadv_o <= 1'b0;

      mem_ncs_o  <= !((nxt == ST_RD) || (nxt == ST_WR));
      mem_noe_o  <= (nxt != ST_RD);
      mem_nwe_o  <= (nxt != ST_WR);
      mem_cre_o  <= (nxt == ST_WR) && req_d.cre;
      // Stay driven through the first REC cycle for data hold.
      dq_oe      <= (nxt == ST_WR) || (state == ST_WR);

      mem_nlb_o  <= 1'b1;
      mem_nub_o  <= 1'b1;
      if (nxt == ST_RD) begin
        mem_nlb_o <= 1'b0;
        mem_nub_o <= (DATA_W == 8);
      end else if ((nxt == ST_WR) && !req_d.cre) begin
        mem_nlb_o <= ~be2[0];
        mem_nub_o <= ~be2[1];
      end

      rsp_valid_q <= ((state == ST_RD) || (state == ST_WR)) && t_zero;
      if ((state == ST_RD) && t_zero) rsp_rdata_q <= mem_dq_io;

      init_done_q <= init_done_q || (nxt == ST_IDLE);
    end
  end

  assign mem_dq_io       = dq_oe ? dq_out : 'z;
  assign bus.req_ready_o = (state == ST_IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.init_done_o = init_done_q;
endmodule

// File: tb/tb_ram_async_ctrl.sv
// Self-checking bench for ram_async_ctrl: behavioural memory device on the
// pins, array-based reference model for expected read data and timing.
module tb_ram_async_ctrl;
  localparam int AW   = 26;
  localparam int DW   = 16;
  localparam int TPW  = 20;
  localparam int TRD  = 7;
  localparam int TWR  = 7;
  localparam int TREC = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_async_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_dq;
  logic ncs, noe, nwe, nadv, mclk, mcre, nub, nlb;

  ram_async_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .T_PWRUP(TPW), .T_RD(TRD), .T_WR(TWR), .T_REC(TREC)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus),
    .mem_addr_o(mem_addr), .mem_dq_io(mem_dq),
    .mem_ncs_o(ncs), .mem_noe_o(noe), .mem_nwe_o(nwe), .mem_nadv_o(nadv),
    .mem_clk_o(mclk), .mem_cre_o(mcre), .mem_nub_o(nub), .mem_nlb_o(nlb)
  );

  // Released bus floats high so an undriven dq is visible.
  for (genvar g = 0; g < DW; g++) begin : g_pu
    pullup (mem_dq[g]);
  end

  // ---------------- memory device model ----------------
  logic [DW-1:0] dev_mem [256] = '{default: 16'h0};
  logic [AW-1:0] bcr = '0;
  assign mem_dq = (!ncs && !noe) ? dev_mem[mem_addr[7:0]] : 'z;

  int acc_len = 0, cre_cnt = 0, nub_low = 0, nlb_low = 0, nwe_cnt = 0;
  int last_len = 0, last_cre = 0, last_nub_low = 0, last_nlb_low = 0, last_nwe = 0;
  int hi_run = 0, ovl_err = 0, rsp_pulses = 0;
  bit seen_acc = 0, wr_seen = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic wr_nub, wr_nlb, wr_cre;

  always @(negedge clk) begin
    if (bus.rsp_valid_o) rsp_pulses <= rsp_pulses + 1;
    if (reset) begin
      acc_len <= 0; cre_cnt <= 0; nub_low <= 0; nlb_low <= 0; nwe_cnt <= 0;
      wr_seen <= 0; hi_run <= 0; seen_acc <= 0;
    end else if (!ncs) begin
      if (acc_len == 0 && seen_acc && hi_run < TREC) ovl_err <= ovl_err + 1;
      hi_run  <= 0;
      acc_len <= acc_len + 1;
      cre_cnt <= cre_cnt + int'(mcre);
      nub_low <= nub_low + int'(!nub);
      nlb_low <= nlb_low + int'(!nlb);
      nwe_cnt <= nwe_cnt + int'(!nwe);
      if (!nwe) begin
        wr_seen <= 1; wr_addr <= mem_addr; wr_data <= mem_dq;
        wr_nub <= nub; wr_nlb <= nlb; wr_cre <= mcre;
      end
    end else begin
      hi_run <= hi_run + 1;
      if (acc_len > 0) begin
        last_len <= acc_len; last_cre <= cre_cnt; last_nub_low <= nub_low;
        last_nlb_low <= nlb_low; last_nwe <= nwe_cnt;
        acc_len <= 0; cre_cnt <= 0; nub_low <= 0; nlb_low <= 0; nwe_cnt <= 0;
        seen_acc <= 1;
      end
      if (wr_seen) begin
        wr_seen <= 0;
        if (wr_cre) bcr <= wr_addr;
        else begin
          if (!wr_nlb) dev_mem[wr_addr[7:0]][7:0]  <= wr_data[7:0];
          if (!wr_nub) dev_mem[wr_addr[7:0]][15:8] <= wr_data[15:8];
        end
      end
    end
  end

  // Acceptance log (cycle index of each accepting edge).
  int cyc = 0;
  int acc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.req_valid_i && bus.req_ready_o) acc_q.push_back(cyc);
  end

  // ---------------- reference model + checking ----------------
  logic [DW-1:0] ref_mem [256] = '{default: 16'h0};
  logic [AW-1:0] bcr_exp = '0;
  logic [DW-1:0] last_rd_exp = '0;
  int n_chk = 0, n_fail = 0;
  localparam logic [31:0] DQ_FLOAT = 32'h0000_FFFF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic do_req(input logic rnw, input logic cre, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [1:0] be);
    bit ok;
    int j;
    logic [7:0] idx;
    @(negedge clk);
    bus.req_valid_i = 1; bus.req_rnw_i = rnw; bus.req_cre_i = cre;
    bus.req_addr_i = a; bus.req_wdata_i = wd; bus.req_be_i = be;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready_o) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      bus.req_valid_i = 0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid_i = 0;
    idx = a[7:0];
    if (rnw) last_rd_exp = ref_mem[idx];
    else if (cre) bcr_exp = a;
    else begin
      if (be[0]) ref_mem[idx][7:0]  = wd[7:0];
      if (be[1]) ref_mem[idx][15:8] = wd[15:8];
    end
    j = 0; ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) begin ok = 1; break; end
      j++;
    end
    chk("rsp_seen", 32'(ok), 1);
    chk("rsp_latency", j, rnw ? TRD : TWR);
    chk("rsp_rdata", bus.rsp_rdata_o, last_rd_exp);
    if (!rnw) chk("dq_hold_rec", mem_dq, wd);
    @(negedge clk);
    chk("rsp_one_cycle", 32'(bus.rsp_valid_o), 0);
    chk("dq_released", mem_dq, DQ_FLOAT);
    chk("access_len", last_len, rnw ? TRD : TWR);
    chk("nwe_low_cycles", last_nwe, rnw ? 0 : TWR);
  endtask

  initial begin
    bit ok, bad;
    int base, p0;
    bus.req_valid_i = 0; bus.req_rnw_i = 0; bus.req_cre_i = 0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_be_i = '0;

    // reset values
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
    chk("rst_init_done", 32'(bus.init_done_o), 0);
    chk("rst_rdata", bus.rsp_rdata_o, 0);
    chk("rst_strobes", {ncs, noe, nwe, nub, nlb, mcre}, 6'b111110);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dq", mem_dq, DQ_FLOAT);
    chk("rst_clk_adv", {mclk, nadv}, 0);

    // power-up wait
    reset = 0;
    bad = 0;
    for (int k = 1; k < TPW; k++) begin
      @(posedge clk); #1;
      if (bus.init_done_o || bus.req_ready_o || !ncs) bad = 1;
    end
    chk("pwrup_hold", 32'(bad), 0);
    @(posedge clk); #1;
    chk("pwrup_done", {bus.init_done_o, bus.req_ready_o}, 2'b11);

    // write then read back
    do_req(0, 0, 26'h000123, 16'hA5C3, 2'b11);
    do_req(1, 0, 26'h000123, 16'h0000, 2'b00);
    chk("rd_a5c3", bus.rsp_rdata_o, 16'hA5C3);

    // low-byte write
    do_req(0, 0, 26'h000123, 16'h00FF, 2'b01);
    chk("byte_wr_nub", last_nub_low, 0);
    chk("byte_wr_nlb", last_nlb_low, TWR);
    do_req(1, 0, 26'h000123, 16'h0000, 2'b00);
    chk("rd_a5ff", bus.rsp_rdata_o, 16'hA5FF);

    // configuration-register write
    do_req(0, 1, 26'h0081D1F, 16'h1234, 2'b11);
    chk("cre_cycles", last_cre, TWR);
    chk("cre_strobes", last_nub_low + last_nlb_low, 0);
    chk("cre_bcr", bcr, bcr_exp);

    // write with no byte enables is still acknowledged and leaves data
    do_req(0, 0, 26'h000123, 16'h1234, 2'b00);
    do_req(1, 0, 26'h000123, 16'h0000, 2'b00);
    chk("be0_keep", bus.rsp_rdata_o, 16'hA5FF);

    // random traffic
    for (int n = 0; n < 24; n++) begin
      do_req(1'($urandom_range(0, 1)), 0, 26'h40 + 26'($urandom_range(0, 15)),
             16'($urandom), 2'($urandom_range(0, 3)));
    end

    // back-to-back reads with valid held
    @(negedge clk);
    base = acc_q.size(); p0 = rsp_pulses;
    bus.req_valid_i = 1; bus.req_rnw_i = 1; bus.req_cre_i = 0; bus.req_addr_i = 26'h40;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_q.size() >= base + 3) begin ok = 1; break; end
    end
    bus.req_valid_i = 0;
    chk("b2b_accepts", 32'(ok), 1);
    if (ok) begin
      chk("b2b_spacing1", acc_q[base+1] - acc_q[base],   TRD + TREC + 1);
      chk("b2b_spacing2", acc_q[base+2] - acc_q[base+1], TRD + TREC + 1);
    end
    repeat (12) @(negedge clk);
    chk("b2b_rsp_count", rsp_pulses - p0, 3);
    chk("b2b_ncs_gap", ovl_err, 0);
    chk("b2b_rdata", bus.rsp_rdata_o, ref_mem[8'h40]);

    // reset in the third write cycle
    @(negedge clk);
    bus.req_valid_i = 1; bus.req_rnw_i = 0; bus.req_cre_i = 0;
    bus.req_addr_i = 26'h80; bus.req_wdata_i = 16'h5A5A; bus.req_be_i = 2'b11;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready_o) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("rstwr_accept", 32'(ok), 1);
    @(posedge clk);
    #1 bus.req_valid_i = 0;
    repeat (3) @(negedge clk);
    chk("rstwr_in_wr", {ncs, nwe}, 2'b00);
    reset = 1;
    p0 = rsp_pulses;
    @(posedge clk); #1;
    chk("rstwr_nwe", 32'(nwe), 1);
    chk("rstwr_ncs", 32'(ncs), 1);
    chk("rstwr_dq", mem_dq, DQ_FLOAT);
    chk("rstwr_ready_init", {bus.req_ready_o, bus.init_done_o}, 2'b00);
    repeat (4) @(negedge clk);
    reset = 0;
    last_rd_exp = '0;
    chk("rstwr_no_rsp", rsp_pulses - p0, 0);
    chk("rstwr_rdata", bus.rsp_rdata_o, 0);
    ok = 0;
    for (int i = 0; i < 2 * TPW; i++) begin
      @(negedge clk);
      if (bus.init_done_o) begin ok = 1; break; end
    end
    chk("reinit_done", 32'(ok), 1);
    do_req(1, 0, 26'h000123, 16'h0000, 2'b00);
    chk("post_rst_rd", bus.rsp_rdata_o, 16'hA5FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_async_ctrl.md
RAM_ASYNC_CTRL -- requirements
Module: ram_async_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 26: memory address width.
REQ-002 SHALL have parameter DATA_W, default 16: data width; legal values 8 and 16.
REQ-003 SHALL have parameter T_PWRUP, default 15000: power-up wait in clk_i cycles (150 us at 100 MHz).
REQ-004 SHALL have parameters T_RD, default 7, and T_WR, default 7: access cycles, each >=1.
REQ-005 SHALL have parameter T_REC, default 1: chip-select recovery cycles, >=1.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock; all logic on rising edge.
REQ-007 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port req_valid_i, input, 1 bit: request present.
REQ-009 SHALL have port req_ready_o, output, 1 bit: request accepted when both high.
REQ-010 SHALL have port req_rnw_i, input, 1 bit: 1 read, 0 write.
REQ-011 SHALL have port req_cre_i, input, 1 bit: configuration-register write, ignored on reads.
REQ-012 SHALL have ports req_addr_i (ADDR_W), req_wdata_i (DATA_W) and req_be_i (DATA_W/8), all inputs: request fields.
REQ-013 SHALL have ports rsp_valid_o (1) and rsp_rdata_o (DATA_W), outputs: completion pulse and read data.
REQ-014 SHALL have port init_done_o, output, 1 bit: power-up wait complete.
REQ-015 SHALL have memory ports, all outputs except mem_dq_io: mem_addr_o (ADDR_W); mem_dq_io (inout, DATA_W); mem_ncs_o, mem_noe_o, mem_nwe_o, mem_nadv_o, mem_clk_o, mem_cre_o, mem_nub_o, mem_nlb_o (1 bit each).

Function
REQ-016 SHALL implement states INIT, IDLE, RD, WR, REC.
REQ-017 SHALL hold INIT for T_PWRUP cycles after reset with mem_ncs_o=1, then enter IDLE and set init_done_o=1 permanently until reset.
REQ-018 SHALL drive req_ready_o=1 only in IDLE; req_valid_i in any other state is ignored and the request is held by the source.
REQ-019 SHALL register addr, wdata, be, rnw and cre on acceptance, then enter RD (rnw=1) or WR (rnw=0) on the next edge.
REQ-020 SHALL register every memory output; mem_clk_o=0, mem_nadv_o=0 constantly (asynchronous mode).
REQ-021 SHALL in RD drive mem_ncs_o=0, mem_noe_o=0, mem_nwe_o=1 for T_RD cycles, capture mem_dq_io into rsp_rdata_o at the edge ending the last RD cycle, and pulse rsp_valid_o=1 for one cycle.
REQ-022 SHALL in WR drive mem_ncs_o=0, mem_nwe_o=0, mem_noe_o=1 and mem_dq_io=wdata for T_WR cycles, then pulse rsp_valid_o=1 for one cycle; rsp_rdata_o is unchanged on writes.
REQ-023 SHALL keep mem_dq_io driven during the first REC cycle after WR (data hold); otherwise mem_dq_io is high-Z.
REQ-024 SHALL in REC drive mem_ncs_o=1, mem_noe_o=1, mem_nwe_o=1 for T_REC cycles, then return to IDLE.
REQ-025 SHALL, for a request accepted at edge N, pulse rsp_valid_o in cycle N+T_RD+1 (read) or N+T_WR+1 (write) and assert req_ready_o again in cycle N+T_{RD|WR}+T_REC+1.
REQ-026 SHALL drive mem_nub_o=~be[1] and mem_nlb_o=~be[0] during access (both 0 on reads); with DATA_W=8, mem_nub_o=1 always.
REQ-027 SHALL on a write with be=0 still run the full WR cycle with both byte strobes high and acknowledge it.
REQ-028 SHALL on cre=1 write drive mem_cre_o=1 for the whole WR cycle with both byte strobes high; mem_cre_o=0 otherwise.
REQ-029 SHALL use a single down-counter loaded on each state entry; no arithmetic wraps.

Reset
REQ-030 SHALL on reset_i=1 at any edge, including mid-access: state INIT with counter reloaded; req_ready_o=0, rsp_valid_o=0, init_done_o=0, rsp_rdata_o=0; mem_ncs_o, mem_noe_o, mem_nwe_o, mem_nub_o, mem_nlb_o=1; mem_cre_o=0; mem_addr_o=0; mem_dq_io high-Z.

Structure
REQ-031 SHALL place the state enumeration and default timing constants in package ram_async_pkg.
REQ-032 SHALL use sub-module ram_async_timer (loadable down-counter with zero flag), width sized from the largest timing parameter.

Verification
REQ-033 SHALL test reset release: T_PWRUP=20 -> init_done_o rises in cycle 20; req_ready_o=0 throughout.
REQ-034 SHALL test a write of 0xA5C3 to 0x000123 with be=11, then a read of 0x000123 against the memory model -> rsp_rdata_o=0xA5C3, rsp_valid_o in cycle N+8.
REQ-035 SHALL test a byte write with be=01, data 0x00FF, over 0xA5C3 -> readback 0xA5FF; mem_nub_o=1 for the whole WR cycle.
REQ-036 SHALL test a CRE write of addr 0x0008_1D1F -> mem_cre_o=1 for 7 cycles and the model's BCR updated.
REQ-037 SHALL test back-to-back requests held valid -> spacing T_RD+T_REC+1 cycles; no overlap on mem_ncs_o.
REQ-038 SHALL test reset asserted in the third WR cycle -> next edge mem_nwe_o=1, mem_dq_io high-Z, state INIT, no rsp_valid_o.
